ws2812_rx: RTL and testbench
============================

WS2812_RX -- requirements
Module: ws2812_rx

Interface
REQ-001 SHALL have parameter ONE_MIN, default 29: high-time cycles at or above which a bit decodes as 1 (0.6 us at 48 MHz).
REQ-002 SHALL have parameter HIGH_MIN, default 7: minimum valid high-time in cycles.
REQ-003 SHALL have parameter HIGH_MAX, default 72: high-time in cycles at which the pulse is declared invalid.
REQ-004 SHALL have parameter RESET_CYC, default 2400: consecutive low cycles that end a frame (50 us).
REQ-005 SHALL have port clk, input, 1: single clock for all logic.
REQ-006 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port din, input, 1: raw WS2812 serial line, asynchronous to clk.
REQ-008 SHALL have port pixel_data, output, 24: last complete pixel, GRB, first-received bit in [23].
REQ-009 SHALL have port pixel_valid, output, 1: one-cycle strobe qualifying pixel_data.
REQ-010 SHALL have port frame_done, output, 1: one-cycle strobe at latch/reset gap.
REQ-011 SHALL have port frame_pixels, output, 10: pixels received in the frame just ended, valid with frame_done.
REQ-012 SHALL have port bit_err, output, 1: one-cycle strobe on any malformed pulse or partial pixel.

Function
REQ-013 SHALL synchronize din through two flip-flops; all decoding uses the synchronized signal din_s.
REQ-014 SHALL detect edges by comparing din_s against its one-cycle delayed copy; all outputs are registered.
REQ-015 SHALL implement states SYNC, IDLE, HIGH, LOW with a 12-bit run counter cnt.
REQ-016 SYNC: cnt counts consecutive low cycles, clears on din_s high; at cnt = RESET_CYC-1 go to IDLE without frame_done.
REQ-017 IDLE: on rising edge go to HIGH with cnt = 1, bit count and pixel count already 0.
REQ-018 HIGH: increment cnt each high cycle; if cnt reaches HIGH_MAX go to SYNC, pulse bit_err, discard partial pixel and frame count.
REQ-019 HIGH, falling edge: cnt < HIGH_MIN -> bit_err, go to SYNC; cnt >= ONE_MIN -> shift in 1; otherwise shift in 0; go to LOW with cnt = 1.
REQ-020 Bits SHALL shift MSB-first into a 24-bit register; a 5-bit bit counter tracks 0..23.
REQ-021 On the 24th bit, pixel_data SHALL load the assembled word, pixel_valid pulses, bit counter wraps to 0, pixel count increments (saturating at 1023).
REQ-022 pixel_valid SHALL assert on the 3rd rising clk edge after the raw din falling edge of bit 24 (2 sync + 1 decode).
REQ-023 LOW: increment cnt; on rising edge go to HIGH with cnt = 1.
REQ-024 LOW at cnt = RESET_CYC-1: pulse frame_done with frame_pixels = pixel count, clear pixel count, go to IDLE.
REQ-025 If bit counter is nonzero at frame end, SHALL pulse bit_err in the same cycle as frame_done, discard partial bits; frame_pixels excludes partial pixel.
REQ-026 pixel_data SHALL hold its value until the next complete pixel; strobes never exceed one cycle.
REQ-027 A rising edge coincident with cnt = RESET_CYC-1 in LOW SHALL be treated as frame end first; the edge then starts a bit from IDLE on the following cycle only if din_s is still high (decode via level, not edge, in IDLE).

Reset
REQ-028 While rst_n low: state SYNC, cnt 0, synchronizer flops 0, pixel_data 0, pixel_valid 0, frame_done 0, frame_pixels 0, bit_err 0, bit and pixel counters 0.
REQ-029 Reset SHALL take effect immediately mid-frame; after release the block SHALL ignore traffic until RESET_CYC low cycles are seen.
REQ-030 No strobe SHALL fire in the cycle rst_n deasserts.

Verification
REQ-031 Reset release, din low 2400 cycles, then 24 bits of 0xA5_3C_0F (T0H 19/T0L 41, T1H 38/T1L 22) -> pixel_valid once, pixel_data = 0xA53C0F.
REQ-032 Three pixels 0xFF0000, 0x00FF00, 0x0000FF then 2400 low cycles -> three pixel_valid strobes in order, then frame_done with frame_pixels = 3.
REQ-033 Bit high for 4 cycles mid-pixel -> bit_err one cycle, no pixel_valid until after 2400 low cycles and a fresh full pixel.
REQ-034 din held high 100 cycles -> bit_err at high cnt 72, state SYNC, no frame_done.
REQ-035 Frame of 1 pixel plus 10 bits then 2400 low -> pixel_valid once, frame_done with frame_pixels = 1 and bit_err in same cycle.
REQ-036 rst_n pulsed low during bit 12 of a pixel -> all outputs 0 immediately; next correctly framed pixel after 2400 low cycles decodes exactly.

Source files
------------

// File: rtl/ws2812_rx.sv
// WS2812 serial line receiver: decodes pulse-width bits into 24-bit GRB pixels.
// Also reports frame ends at the latch gap and flags malformed pulses.
module ws2812_rx #(
    parameter int unsigned ONE_MIN   = 29,
    parameter int unsigned HIGH_MIN  = 7,
    parameter int unsigned HIGH_MAX  = 72,
    parameter int unsigned RESET_CYC = 2400
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        din,
    output logic [23:0] pixel_data,
    output logic        pixel_valid,
    output logic        frame_done,
    output logic [9:0]  frame_pixels,
    output logic        bit_err
);

    localparam logic [11:0] ResetLast = 12'(RESET_CYC - 1);
    localparam logic [11:0] HighLast  = 12'(HIGH_MAX - 1);
    localparam logic [11:0] OneMin    = 12'(ONE_MIN);
    localparam logic [11:0] HighMin   = 12'(HIGH_MIN);

    typedef enum logic [1:0] {StSync, StIdle, StHigh, StLow} state_e;

    state_e      state_q, state_d;
    logic [11:0] cnt_q, cnt_d;
    logic [22:0] shreg_q, shreg_d;
    logic [4:0]  bit_cnt_q, bit_cnt_d;
    logic [9:0]  pix_cnt_q, pix_cnt_d;
    logic [23:0] pixel_data_q, pixel_data_d;
    logic [9:0]  frame_pixels_q, frame_pixels_d;
    logic        pixel_valid_q, pixel_valid_d;
    logic        frame_done_q, frame_done_d;
    logic        bit_err_q, bit_err_d;

    logic        din_meta_q, din_s, din_prev_q;
    logic        rise, fall, bit_val;
    logic [23:0] word;

    assign rise    = din_s & ~din_prev_q;
    assign fall    = ~din_s & din_prev_q;
    assign bit_val = (cnt_q >= OneMin);
    assign word    = {shreg_q, bit_val};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            din_meta_q     <= 1'b0;
            din_s          <= 1'b0;
            din_prev_q     <= 1'b0;
            state_q        <= StSync;
            cnt_q          <= '0;
            shreg_q        <= '0;
            bit_cnt_q      <= '0;
            pix_cnt_q      <= '0;
            pixel_data_q   <= '0;
            frame_pixels_q <= '0;
            pixel_valid_q  <= 1'b0;
            frame_done_q   <= 1'b0;
            bit_err_q      <= 1'b0;
        end else begin
            din_meta_q     <= din;
            din_s          <= din_meta_q;
            din_prev_q     <= din_s;
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            shreg_q        <= shreg_d;
            bit_cnt_q      <= bit_cnt_d;
            pix_cnt_q      <= pix_cnt_d;
            pixel_data_q   <= pixel_data_d;
            frame_pixels_q <= frame_pixels_d;
            pixel_valid_q  <= pixel_valid_d;
            frame_done_q   <= frame_done_d;
            bit_err_q      <= bit_err_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        shreg_d        = shreg_q;
        bit_cnt_d      = bit_cnt_q;
        pix_cnt_d      = pix_cnt_q;
        pixel_data_d   = pixel_data_q;
        frame_pixels_d = frame_pixels_q;
        pixel_valid_d  = 1'b0;
        frame_done_d   = 1'b0;
        bit_err_d      = 1'b0;

        unique case (state_q)
            StSync: begin
                bit_cnt_d = '0;
                pix_cnt_d = '0;
                if (din_s) begin
                    cnt_d = '0;
                end else if (cnt_q == ResetLast) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 12'd1;
                end
            end
            // Level, not edge: a bit may start the cycle after a frame end.
            StIdle: begin
                if (din_s) begin
                    state_d = StHigh;
                    cnt_d   = 12'd1;
                end
            end
            StHigh: begin
                if (fall) begin
                    if (cnt_q < HighMin) begin
                        state_d   = StSync;
                        cnt_d     = '0;
                        bit_err_d = 1'b1;
                        bit_cnt_d = '0;
                        pix_cnt_d = '0;
                    end else begin
                        state_d = StLow;
                        cnt_d   = 12'd1;
                        if (bit_cnt_q == 5'd23) begin
                            pixel_data_d  = word;
                            pixel_valid_d = 1'b1;
                            bit_cnt_d     = '0;
                            pix_cnt_d     = (pix_cnt_q == 10'h3FF) ? pix_cnt_q
                                                                   : pix_cnt_q + 10'd1;
                        end else begin
                            shreg_d   = word[22:0];
                            bit_cnt_d = bit_cnt_q + 5'd1;
                        end
                    end
                end else if (cnt_q == HighLast) begin
                    state_d   = StSync;
                    cnt_d     = '0;
                    bit_err_d = 1'b1;
                    bit_cnt_d = '0;
                    pix_cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + 12'd1;
                end
            end
            StLow: begin
                if (cnt_q == ResetLast) begin
                    state_d        = StIdle;
                    cnt_d          = '0;
                    frame_done_d   = 1'b1;
                    frame_pixels_d = pix_cnt_q;
                    bit_err_d      = (bit_cnt_q != 5'd0);
                    bit_cnt_d      = '0;
                    pix_cnt_d      = '0;
                end else if (rise) begin
                    state_d = StHigh;
                    cnt_d   = 12'd1;
                end else begin
                    cnt_d = cnt_q + 12'd1;
                end
            end
            default: state_d = StSync;
        endcase
    end

    assign pixel_data   = pixel_data_q;
    assign pixel_valid  = pixel_valid_q;
    assign frame_done   = frame_done_q;
    assign frame_pixels = frame_pixels_q;
    assign bit_err      = bit_err_q;

endmodule

// File: tb/tb_ws2812_rx.sv
// Scoreboard bench for ws2812_rx: driver queues expected strobes, monitor pops and compares.
module tb_ws2812_rx;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        din = 1'b0;
    logic [23:0] pixel_data;
    logic        pixel_valid;
    logic        frame_done;
    logic [9:0]  frame_pixels;
    logic        bit_err;

    ws2812_rx dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .din          (din),
        .pixel_data   (pixel_data),
        .pixel_valid  (pixel_valid),
        .frame_done   (frame_done),
        .frame_pixels (frame_pixels),
        .bit_err      (bit_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        pv;
        logic        fd;
        logic        be;
        logic [23:0] pd;
        logic [9:0]  fp;
    } ev_t;

    ev_t         exp_q[$];
    string       name_q[$];
    ev_t         e;
    string       ename;
    int          vectors = 0;
    int          miscompares = 0;
    int unsigned cyc = 0;
    int unsigned fall_cyc = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: every strobe must match the head of the expectation queue.
    initial forever begin
        @(negedge clk);
        if (pixel_valid || frame_done || bit_err) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_strobe: got pv=%0b fd=%0b be=%0b pd=%06h fp=%0d, required none",
                         pixel_valid, frame_done, bit_err, pixel_data, frame_pixels);
            end else begin
                e     = exp_q.pop_front();
                ename = name_q.pop_front();
                if ({pixel_valid, frame_done, bit_err} !== {e.pv, e.fd, e.be} ||
                    (e.pv && pixel_data !== e.pd) || (e.fd && frame_pixels !== e.fp)) begin
                    miscompares++;
                    $display("FAIL %s: got pv=%0b fd=%0b be=%0b pd=%06h fp=%0d, required pv=%0b fd=%0b be=%0b pd=%06h fp=%0d",
                             ename, pixel_valid, frame_done, bit_err, pixel_data, frame_pixels,
                             e.pv, e.fd, e.be, e.pd, e.fp);
                end
            end
            if (pixel_valid) begin
                vectors++;
                if (cyc - fall_cyc != 3) begin
                    miscompares++;
                    $display("FAIL pixel_latency: got %0d clk edges after final fall, required 3",
                             cyc - fall_cyc);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] req);
        vectors++;
        if (got !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, required %0h", n, got, req);
        end
    endtask

    task automatic chk_zero(input string n);
        chk({n, "_pixel_data"}, 32'(pixel_data), 32'd0);
        chk({n, "_pixel_valid"}, 32'(pixel_valid), 32'd0);
        chk({n, "_frame_done"}, 32'(frame_done), 32'd0);
        chk({n, "_frame_pixels"}, 32'(frame_pixels), 32'd0);
        chk({n, "_bit_err"}, 32'(bit_err), 32'd0);
    endtask

    task automatic push(input string n, input logic pv, input logic fd, input logic be,
                        input logic [23:0] pd, input logic [9:0] fp);
        ev_t x;
        x.pv = pv; x.fd = fd; x.be = be; x.pd = pd; x.fp = fp;
        exp_q.push_back(x);
        name_q.push_back(n);
    endtask

    task automatic low(input int n);
        din = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        din = 1'b1;
        repeat (b ? 38 : 19) @(negedge clk);
        din = 1'b0;
        fall_cyc = cyc;
        repeat (b ? 22 : 41) @(negedge clk);
    endtask

    task automatic send_bits(input logic [23:0] v, input int nbits);
        for (int i = 23; i > 23 - nbits; i--) send_bit(v[i]);
    endtask

    task automatic pixel(input string n, input logic [23:0] v);
        push(n, 1'b1, 1'b0, 1'b0, v, 10'd0);
        send_bits(v, 24);
    endtask

    task automatic frame_end(input string n, input logic [9:0] fp, input logic be);
        push(n, 1'b0, 1'b1, be, 24'd0, fp);
        low(2450);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst_n = 1'b1;
        low(2410);

        pixel("pix_a53c0f", 24'hA53C0F);
        frame_end("frame_one", 10'd1, 1'b0);

        pixel("pix_red", 24'hFF0000);
        pixel("pix_green", 24'h00FF00);
        pixel("pix_blue", 24'h0000FF);
        frame_end("frame_three", 10'd3, 1'b0);

        // Short high pulse mid-pixel; following bits are ignored until resync.
        push("short_pulse_err", 1'b0, 1'b0, 1'b1, 24'd0, 10'd0);
        send_bits(24'hF0F0F0, 5);
        din = 1'b1;
        repeat (4) @(negedge clk);
        low(30);
        send_bits(24'hFFFFFF, 19);
        low(2450);
        pixel("pix_after_short", 24'h123456);
        frame_end("frame_after_short", 10'd1, 1'b0);

        push("stuck_high_err", 1'b0, 1'b0, 1'b1, 24'd0, 10'd0);
        din = 1'b1;
        repeat (100) @(negedge clk);
        low(2450);

        pixel("pix_before_partial", 24'h0F0F0F);
        push("frame_partial", 1'b0, 1'b1, 1'b1, 24'd0, 10'd1);
        send_bits(24'h55AA00, 10);
        low(2450);

        send_bits(24'hC3C3C3, 11);
        din = 1'b1;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_zero("midframe_reset");
        @(negedge clk);
        din = 1'b0;
        repeat (3) @(negedge clk);
        chk_zero("held_reset");
        rst_n = 1'b1;
        low(2410);
        pixel("pix_after_reset", 24'hC0FFEE);
        frame_end("frame_after_reset", 10'd1, 1'b0);

        repeat (10) @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
